// File: rtl/mem_pkg.sv
// Shared types and beat-count constants for the memory stage and its stack sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } stack_state_t;

  typedef enum logic [1:0] {
    ADDR_ALU  = 2'd0,
    ADDR_RD2  = 2'd1,
    ADDR_RSV2 = 2'd2,
    ADDR_RSV3 = 2'd3
  } addr_sel_t;

  typedef enum logic [1:0] {
    WSRC_REG      = 2'd0,
    WSRC_PC       = 2'd1,
    WSRC_PC_FLAGS = 2'd2,
    WSRC_ZERO     = 2'd3
  } wsrc_sel_t;

  localparam logic [1:0] BEATS_PUSH = 2'd1;
  localparam logic [1:0] BEATS_POP  = 2'd1;
  localparam logic [1:0] BEATS_CALL = 2'd2;
  localparam logic [1:0] BEATS_RET  = 2'd2;
  localparam logic [1:0] BEATS_INT  = 2'd3;
  localparam logic [1:0] BEATS_RTI  = 2'd3;

  function automatic logic [1:0] push_beats(input wsrc_sel_t src);
    case (src)
      WSRC_PC:       return BEATS_CALL;
      WSRC_PC_FLAGS: return BEATS_INT;
      default:       return BEATS_PUSH;
    endcase
  endfunction

  function automatic logic [1:0] pop_beats(input logic ret, input logic rti);
    if (rti) return BEATS_RTI;
    if (ret) return BEATS_RET;
    return BEATS_POP;
  endfunction

endpackage

// File: rtl/stack_sequencer.sv
// Beat sequencer for multi-word stack operations: beat FSM, stack pointer and stall.
module stack_sequencer
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int SP_RESET = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [1:0]        beats,
  output logic [1:0]        beat,
  output logic              last_beat,
  output logic              stall,
  output logic [ADDR_W-1:0] stack_addr,
  output logic [ADDR_W-1:0] sp
);

  localparam logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_RESET);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  stack_state_t      state_q, state_d;
  logic [ADDR_W-1:0] sp_q;
  logic              op_active;

  assign op_active  = push | pop;
  assign beat       = state_q;
  assign last_beat  = (beat == beats - 2'd1);
  assign stall      = op_active & ~last_beat;
  // Push writes the current top slot; pop reads the slot it is about to uncover.
  assign stack_addr = push ? sp_q : sp_q + ONE;
  assign sp         = sp_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d = IDLE;
    if (stall) begin
      case (state_q)
        IDLE:    state_d = BEAT1;
        BEAT1:   state_d = BEAT2;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sp_q    <= SP_INIT;
    end else begin
      state_q <= state_d;
      if (push)     sp_q <= sp_q - ONE;
      else if (pop) sp_q <= sp_q + ONE;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: data-memory address/data muxing, stack sequencing and the MEM/WB register.
module memory_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int SP_RESET = 2**ADDR_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       alu_result,
  input  logic [15:0]       read_data1,
  input  logic [15:0]       read_data2,
  input  logic [15:0]       LDM_value,
  input  logic [15:0]       inPortValue,
  input  logic [31:0]       pc_plus_one,
  input  logic [2:0]        flag_register,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_push,
  input  logic              mem_pop,
  input  logic              pc_choose_memory,
  input  logic              pc_choose_interrupt,
  input  logic [1:0]        memory_address_select,
  input  logic [1:0]        memory_write_src_select,
  input  logic              reg_write,
  input  logic              outport_enable,
  input  logic [1:0]        wb_sel,
  input  logic [2:0]        reg_write_address,
  input  logic [15:0]       dmem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [15:0]       dmem_wdata,
  output logic              dmem_we,
  output logic              stall,
  output logic [15:0]       mem_data_out,
  output logic [15:0]       alu_result_out,
  output logic [15:0]       LDM_value_out,
  output logic [15:0]       inPortValue_out,
  output logic              reg_write_out,
  output logic              outport_enable_out,
  output logic [1:0]        wb_sel_out,
  output logic [2:0]        reg_write_address_out,
  output logic [31:0]       pc_from_memory,
  output logic              pc_from_memory_valid,
  output logic [2:0]        conditions_from_memory_pop,
  output logic              flags_restore_valid,
  output logic [ADDR_W-1:0] sp
);

  wsrc_sel_t         wsrc;
  addr_sel_t         asel;
  logic              push, pop, stack_op, ret_pop, rti_pop, plain_pop, load;
  logic [1:0]        beats, beat;
  logic              last_beat;
  logic [ADDR_W-1:0] stack_addr, data_addr;
  logic [15:0]       pc_lo_q;
  logic [2:0]        flags_q;

  assign wsrc      = wsrc_sel_t'(memory_write_src_select);
  assign asel      = addr_sel_t'(memory_address_select);
  assign push      = mem_push;
  assign pop       = mem_pop & ~mem_push;
  assign stack_op  = mem_push | mem_pop;
  assign rti_pop   = pop & pc_choose_interrupt;
  assign ret_pop   = pop & pc_choose_memory & ~pc_choose_interrupt;
  assign plain_pop = pop & ~pc_choose_memory & ~pc_choose_interrupt;
  assign load      = mem_read & ~mem_write & ~stack_op;
  assign beats     = push ? push_beats(wsrc)
                   : pop  ? pop_beats(ret_pop, rti_pop)
                   : 2'd1;

  stack_sequencer #(
    .ADDR_W   (ADDR_W),
    .SP_RESET (SP_RESET)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .beats      (beats),
    .beat       (beat),
    .last_beat  (last_beat),
    .stall      (stall),
    .stack_addr (stack_addr),
    .sp         (sp)
  );

  always_comb begin
    data_addr = '0;
    case (asel)
      ADDR_ALU: data_addr = alu_result[ADDR_W-1:0];
      ADDR_RD2: data_addr = read_data2[ADDR_W-1:0];
      default:  data_addr = '0;
    endcase
  end

  // Pushes store high PC word first so pops see the reverse order: flags, low, high.
  always_comb begin
    dmem_wdata = read_data1;
    if (push) begin
      case (wsrc)
        WSRC_REG: dmem_wdata = read_data1;
        WSRC_PC, WSRC_PC_FLAGS: begin
          case (beat)
            2'd0:    dmem_wdata = pc_plus_one[31:16];
            2'd1:    dmem_wdata = pc_plus_one[15:0];
            default: dmem_wdata = {13'b0, flag_register};
          endcase
        end
        default: dmem_wdata = '0;
      endcase
    end
  end

  assign dmem_addr = stack_op ? stack_addr : data_addr;
  assign dmem_we   = push | (mem_write & ~stack_op);

  generate
    if (ADDR_W < 16) begin : g_rd2_hi
      logic unused_rd2_hi;
      assign unused_rd2_hi = ^read_data2[15:ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_data_out               <= '0;
      alu_result_out             <= '0;
      LDM_value_out              <= '0;
      inPortValue_out            <= '0;
      reg_write_out              <= 1'b0;
      outport_enable_out         <= 1'b0;
      wb_sel_out                 <= '0;
      reg_write_address_out      <= '0;
      pc_from_memory             <= '0;
      pc_from_memory_valid       <= 1'b0;
      conditions_from_memory_pop <= '0;
      flags_restore_valid        <= 1'b0;
      pc_lo_q                    <= '0;
      flags_q                    <= '0;
    end else begin
      alu_result_out        <= alu_result;
      LDM_value_out         <= LDM_value;
      inPortValue_out       <= inPortValue;
      wb_sel_out            <= wb_sel;
      reg_write_address_out <= reg_write_address;
      // Non-final beats hand write-back a bubble.
      reg_write_out         <= reg_write & ~stall;
      outport_enable_out    <= outport_enable & ~stall;
      pc_from_memory_valid  <= 1'b0;
      flags_restore_valid   <= 1'b0;

      if (rti_pop && beat == 2'd0) flags_q <= dmem_rdata[2:0];
      if ((ret_pop && beat == 2'd0) || (rti_pop && beat == 2'd1)) pc_lo_q <= dmem_rdata;

      if (last_beat) begin
        if (load || plain_pop) mem_data_out <= dmem_rdata;
        if (ret_pop || rti_pop) begin
          pc_from_memory       <= {dmem_rdata, pc_lo_q};
          pc_from_memory_valid <= 1'b1;
        end
        if (rti_pop) begin
          conditions_from_memory_pop <= flags_q;
          flags_restore_valid        <= 1'b1;
        end
      end
    end
  end

endmodule
